// File: rtl/pla_onset_scanner.sv
// Drives a contiguous (wrapping) range of minterms onto a single-output PLA, one per clock,
// and accumulates onset size, first onset minterm and a MISR signature of the response.
module pla_onset_scanner #(
  parameter int          N_IN     = 16,
  parameter logic [15:0] SIG_POLY = 16'h1021,
  parameter logic [15:0] SIG_INIT = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [N_IN-1:0] lo,
  input  logic [N_IN-1:0] hi,
  output logic [N_IN-1:0] x_vec,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   onset_count,
  output logic [N_IN-1:0] first_onset,
  output logic            first_valid,
  output logic [15:0]     signature
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] hi_q;
  logic [15:0]     sig_next;

  // Shifting y_in into bit 0 is the same as (sig<<1) ^ y_in, since the shift leaves bit 0 clear.
  always_comb begin
    sig_next = {signature[14:0], y_in} ^ (signature[15] ? SIG_POLY : 16'h0000);
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values of x_vec and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hi_q        <= '0;
      x_vec       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      onset_count <= '0;
      first_onset <= '0;
      first_valid <= 1'b0;
      signature   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            hi_q        <= hi;
            x_vec       <= lo;
            busy        <= 1'b1;
            done        <= 1'b0;
            onset_count <= '0;
            first_onset <= '0;
            first_valid <= 1'b0;
            signature   <= SIG_INIT;
          end
        end
        RUN: begin
          if (abort) begin
            // The sample on x_vec at this edge is dropped; partial results stay visible.
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            onset_count <= onset_count + (N_IN+1)'(y_in);
            signature   <= sig_next;
            if (y_in && !first_valid) begin
              first_onset <= x_vec;
              first_valid <= 1'b1;
            end
            if (x_vec == hi_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              x_vec <= x_vec + N_IN'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pla_onset_scanner.sv
// Bench for pla_onset_scanner: stub networks and a small sum-of-products PLA answer x_vec,
// results are compared against a range-walking reference model.
module tb_pla_onset_scanner;

  logic        clk = 1'b0;
  logic        rst, start, abort, y_in;
  logic [15:0] lo, hi, x_vec;
  logic        busy, done, first_valid;
  logic [16:0] onset_count;
  logic [15:0] first_onset, signature;

  int mode;
  int total = 0;
  int bad   = 0;

  pla_onset_scanner #(.N_IN(16), .SIG_POLY(16'h1021), .SIG_INIT(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .x_vec(x_vec), .y_in(y_in), .busy(busy), .done(done), .onset_count(onset_count),
    .first_onset(first_onset), .first_valid(first_valid), .signature(signature)
  );

  initial forever #5 clk = ~clk;

  // Stand-in for a benchmark PLA network: a handful of product terms.
  function automatic logic pla(input logic [15:0] x);
    return (x[0] & x[3] & ~x[7]) | (x[12] & ~x[1] & x[9]) |
           (x[5] & x[10] & x[15] & ~x[2]) | (~x[4] & ~x[6] & x[8] & x[11] & x[14]);
  endfunction

  // mode 0: y=x[0], 1: constant 0, 2: constant 1, 3: PLA
  function automatic logic fy(input int m, input logic [15:0] x);
    case (m)
      0:       return x[0];
      1:       return 1'b0;
      2:       return 1'b1;
      default: return pla(x);
    endcase
  endfunction

  always_comb y_in = fy(mode, x_vec);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the range as integers, counting ones and folding the MISR arithmetically.
  task automatic model(input logic [15:0] l, input logic [15:0] h, input int m,
                       output int n, output int cnt, output logic [15:0] first,
                       output logic valid, output logic [15:0] sig);
    int v, s, y;
    v = l; n = 0; cnt = 0; first = '0; valid = 1'b0; s = 'hFFFF;
    while (1) begin
      y = int'(fy(m, v[15:0]));
      n++;
      cnt += y;
      if (y == 1 && !valid) begin
        first = v[15:0];
        valid = 1'b1;
      end
      s = ((s * 2) % 65536) ^ ((s >= 32768) ? 'h1021 : 0) ^ y;
      if (v == int'(h)) break;
      v = (v + 1) % 65536;
    end
    sig = s[15:0];
  endtask

  // Run one scan; abort_at>0 asserts abort (with start) so it is sampled at edge E<abort_at>.
  task automatic scan(input logic [15:0] l, input logic [15:0] h, input int abort_at,
                      output int cycles, output int xerr);
    int v;
    v = int'(l); cycles = 0; xerr = 0;
    @(negedge clk);
    lo = l; hi = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lo = 16'($urandom); hi = 16'($urandom);
    check("start_state", {busy, done, first_valid, onset_count, signature},
          {1'b1, 1'b0, 1'b0, 17'd0, 16'hFFFF});
    while (busy && cycles < 70000) begin
      if (x_vec !== v[15:0]) xerr++;
      if (cycles == 2) start = 1'b1;
      if (cycles + 1 == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      cycles++;
      v = (v + 1) % 65536;
    end
  endtask

  typedef struct {
    logic [15:0] lo, hi;
    int          mode, abort_at, n, cnt;
    logic [15:0] first;
    logic        valid, chk_sig;
    logic [15:0] sig, x_end;
    logic        done_end;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int cycles, xerr, n, cnt;
    logic [15:0] first, sig, rl, rh;
    logic valid;

    tbl[0] = '{16'h0000, 16'h0007, 0, 0, 8, 4, 16'h0001, 1'b1, 1'b0, 16'h0, 16'h0007, 1'b1};
    tbl[1] = '{16'hFFFE, 16'h0001, 0, 0, 4, 2, 16'hFFFF, 1'b1, 1'b0, 16'h0, 16'h0001, 1'b1};
    tbl[2] = '{16'h0005, 16'h0005, 1, 0, 1, 0, 16'h0000, 1'b0, 1'b1, 16'hEFDF, 16'h0005, 1'b1};
    tbl[3] = '{16'h0000, 16'd99, 2, 40, 40, 39, 16'h0000, 1'b1, 1'b0, 16'h0, 16'd39, 1'b0};
    tbl[4] = '{16'h0000, 16'd99, 2, 0, 100, 100, 16'h0000, 1'b1, 1'b0, 16'h0, 16'd99, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; lo = '0; hi = '0; mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {x_vec, busy, done, onset_count, first_onset, first_valid, signature}, 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      scan(tbl[i].lo, tbl[i].hi, tbl[i].abort_at, cycles, xerr);
      check($sformatf("cycles[%0d]", i), cycles, tbl[i].n);
      check($sformatf("xseq[%0d]", i), xerr, 0);
      check($sformatf("count[%0d]", i), onset_count, tbl[i].cnt);
      check($sformatf("first[%0d]", i), {first_valid, first_onset}, {tbl[i].valid, tbl[i].first});
      check($sformatf("end[%0d]", i), {busy, done, x_vec}, {1'b0, tbl[i].done_end, tbl[i].x_end});
      if (tbl[i].chk_sig) check($sformatf("sig[%0d]", i), signature, tbl[i].sig);
      @(negedge clk);
      check($sformatf("settled[%0d]", i), {busy, done}, {1'b0, tbl[i].done_end});
    end

    // abort while DONE is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_done", {busy, done, onset_count}, {1'b1, 1'b0, 17'd0} ^ {1'b1, 1'b1, 17'd100});

    // randomized partial scans of the PLA, half of them wrapping through all-ones
    mode = 3;
    for (int i = 0; i < 6; i++) begin
      rl = (i % 2 == 1) ? 16'hFFFF - 16'($urandom_range(0, 20)) : 16'($urandom);
      rh = rl + 16'($urandom_range(0, 300));
      model(rl, rh, 3, n, cnt, first, valid, sig);
      scan(rl, rh, 0, cycles, xerr);
      check($sformatf("rnd_cycles[%0d]", i), cycles, n);
      check($sformatf("rnd_xseq[%0d]", i), xerr, 0);
      check($sformatf("rnd_result[%0d]", i), {onset_count, first_valid, first_onset, signature},
            {17'(cnt), valid, first, sig});
    end

    // full 65536-minterm wrap scan (lo = hi+1) with every output at 1
    mode = 2;
    model(16'h8000, 16'h7FFF, 2, n, cnt, first, valid, sig);
    scan(16'h8000, 16'h7FFF, 0, cycles, xerr);
    check("full_cycles", cycles, 65536);
    check("full_xseq", xerr, 0);
    check("full_count", onset_count, 17'd65536);
    check("full_result", {first_valid, first_onset, signature, done}, {valid, first, sig, 1'b1});

    // reset mid-scan with start held high
    mode = 3;
    @(negedge clk);
    lo = 16'h0100; hi = 16'h0900; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_midscan", {x_vec, busy, done, onset_count, first_onset, first_valid, signature}, 64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_no_scan", {busy, done, x_vec}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pla_onset_scanner.md
# pla_onset_scanner

Sequential vector sequencer and response accumulator for the 16-input, single-output combinational PLA benchmark networks. It drives a contiguous range of input minterms onto the network, one per clock. It samples the network output `y0` for every minterm and reports the onset size, the first onset minterm, and a 16-bit response signature. It sits directly around the benchmark netlist: `x_vec` feeds `x0..x15`, and `y_in` takes `y0`. This allows the original and the D-reduced or optimized netlists to be compared on hardware or in simulation.

## Interface
Parameters:
- `N_IN`, 16: input width of the network under test; `x_vec[i]` drives `x<i>`.
- `SIG_POLY`, 16'h1021: feedback polynomial of the signature register.
- `SIG_INIT`, 16'hFFFF: value loaded into `signature` on start.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a scan; sampled in IDLE or DONE only.
- `abort`  in  1  stop a scan; sampled in RUN only.
- `lo`  in  N_IN  first minterm of the range; latched on start.
- `hi`  in  N_IN  last minterm of the range, inclusive; latched on start.
- `x_vec`  out  N_IN  registered minterm driven to the network.
- `y_in`  in  1  network output `y0`; combinational function of `x_vec`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE, held until the next start or reset.
- `onset_count`  out  N_IN+1  number of scanned minterms with `y_in`=1.
- `first_onset`  out  N_IN  first scanned minterm with `y_in`=1.
- `first_valid`  out  1  `first_onset` holds a valid minterm.
- `signature`  out  16  MISR of the `y_in` sequence.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE.
- Reset values: `x_vec`=0, `busy`=0, `done`=0, `onset_count`=0, `first_onset`=0, `first_valid`=0, `signature`=0.
- IDLE or DONE with `start`=1:
  - latch `lo` and `hi`; load `x_vec`=`lo`;
  - clear `onset_count`, `first_valid` and `first_onset`; load `signature`=`SIG_INIT`;
  - go to RUN.
- RUN, on every edge, for the current `x_vec`=v:
  - `onset_count` += `y_in`;
  - if `y_in`=1 and `first_valid`=0, set `first_onset`=v and `first_valid`=1;
  - `signature` <= (`signature`<<1) ^ (`signature[15]` ? `SIG_POLY` : 0) ^ {15'b0,`y_in`}.
- RUN, end of range: if v equals the latched `hi`, go to DONE and hold `x_vec`. Otherwise `x_vec` <= v+1 mod 2^N_IN.
- Wrap-around:
  - if `lo` > `hi`, the scan runs `lo`..all-ones, then 0..`hi`;
  - `lo`=`hi`+1 (mod 2^16) scans all 65536 minterms;
  - `lo`=`hi` scans exactly one minterm.
- `onset_count` is N_IN+1 bits, so a full scan with every output at 1 gives 65536 without overflow.
- `abort`=1 in RUN:
  - go to IDLE; `done` stays 0;
  - the sample for the current edge is not accumulated;
  - partial results and `x_vec` hold.
- `abort` outside RUN is ignored.
- `start` in RUN is ignored.
- `start` and `abort` both high in RUN: `abort` wins.
- `rst` overrides everything in the same edge, including mid-scan.
- `lo`/`hi` changes after the start edge do not affect a running scan.

## Timing
- `start` is sampled at edge E0. After E0, `x_vec`=`lo` and `busy`=1.
- Minterm k (k=0..N-1) of an N-minterm scan is on `x_vec` between edges Ek and Ek+1. It is accumulated at edge Ek+1.
- After edge EN: `busy`=0, `done`=1, and all results are final. Start to done therefore takes N cycles; throughput is one minterm per cycle.
- `y_in` is purely combinational from `x_vec` inside one cycle. No DUT pipeline is supported.
- All outputs are registered.
- A restart from DONE at edge E0 drops `done` after E0 and clears the results at that same edge.

## Test plan
- Stub `y_in`=`x_vec[0]`, `lo`=0, `hi`=7 -> `done` after 8 cycles; `onset_count`=4, `first_onset`=1, `first_valid`=1.
- Same stub, `lo`=16'hFFFE, `hi`=16'h0001 -> 4 cycles; `x_vec` sequence FFFE, FFFF, 0000, 0001; `onset_count`=2, `first_onset`=16'hFFFF.
- Stub `y_in`=0, `lo`=`hi`=5 -> `done` after 1 cycle; `onset_count`=0, `first_valid`=0, `signature`=(16'hFFFF<<1)^16'h1021=16'hEFDF.
- Real benchmark netlist, `lo`=0, `hi`=16'hFFFF -> `done` after 65536 cycles. `onset_count`, `first_onset` and `signature` must match a software model of the same PLA. Run against both the original and the optimized netlist; their results must be identical.
- Stub `y_in`=1, scan 0..99, `abort` at cycle 40 -> IDLE with `done`=0 and `onset_count`=39. A later `start` restarts cleanly with `onset_count`=100.
- `rst` asserted mid-scan with `start` also high -> all outputs at their reset values after the edge; state IDLE; no scan begins.
